wb_sequencer: RTL and testbench
===============================

WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 SHALL have ports: CLK  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: RST_N  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: WB_VALID  in  1  instruction present in write-back stage.
REQ-004 SHALL have ports: OPCODE  in  32  instruction word in write-back stage.
REQ-005 SHALL have ports: COND_PASS  in  1  condition field evaluated true.
REQ-006 SHALL have ports: WB_CTL  in  3  write-back control: [2] WB_FWD_SEL, [1] REG_WDAT_Sel, [0] REG_W, already qualified by GCnt.
REQ-007 SHALL have ports: ALU_RES  in  32; MEM_DAT  in  32  candidate write data.
REQ-008 SHALL have ports: GCnt  out  1  beat index fed back to write-back control decode.
REQ-009 SHALL have ports: STALL  out  1  hold upstream stages, combinational.
REQ-010 SHALL have ports: REG_WE  out  1; REG_WADDR  out  4; REG_WDAT  out  32  register-file write port, registered.
REQ-011 SHALL have ports: FWD_VALID  out  1; FWD_ADDR  out  4; FWD_DAT  out  32  forwarding bus, registered.
REQ-012 SHALL have ports: PC_WR  out  1  registered pulse, R15 written (pipeline flush).

Function
REQ-013 SHALL implement two states: B0 (GCnt=0) and B1 (GCnt=1); GCnt SHALL equal the state bit.
REQ-014 Multi-beat instruction (MB) SHALL be WB_VALID & COND_PASS & OPCODE[27:26]==2'b01.
REQ-015 B0 with MB SHALL assert STALL=1 and transition to B1 on next edge; otherwise remain B0, STALL=0.
REQ-016 B1 SHALL hold STALL=0 and unconditionally return to B0 on next edge; inputs held stable by upstream during B1.
REQ-017 Effective write enable WE_EFF SHALL be WB_VALID & COND_PASS & WB_CTL[0].
REQ-018 Write address SHALL be OPCODE[19:16] (Rn, base) when OPCODE[27:26]==01 and GCnt=1, else OPCODE[15:12] (Rd).
REQ-019 Write data SHALL be MEM_DAT when WB_CTL[1]=1, else ALU_RES; full 32 bits, no extension.
REQ-020 Forward data SHALL be MEM_DAT when WB_CTL[2]=1, else ALU_RES; forward address identical to write address.
REQ-021 On each edge REG_WE and FWD_VALID SHALL load WE_EFF; REG_WADDR/FWD_ADDR, REG_WDAT/FWD_DAT SHALL load the selected values (one-cycle latency).
REQ-022 PC_WR SHALL load WE_EFF & (write address==4'hF); one-cycle pulse per beat.
REQ-023 COND_PASS=0 or WB_VALID=0 SHALL produce no write, no stall, single beat.
REQ-024 Two writes from one MB SHALL appear on consecutive cycles, beat-0 first; no beat may be skipped or repeated.
REQ-025 WB_VALID falling while in B1 SHALL still return to B0 with no write that cycle.

Reset
REQ-026 RST_N low SHALL immediately force B0, GCnt=0, REG_WE=0, REG_WADDR=0, REG_WDAT=0, FWD_VALID=0, FWD_ADDR=0, FWD_DAT=0, PC_WR=0, independent of CLK.
REQ-027 Reset asserted in B1 SHALL abandon the second beat; after release first edge behaves as B0.
REQ-028 STALL SHALL be 0 during reset regardless of inputs.

Verification
REQ-029 Data-processing OPCODE=32'hE0812003, WB_CTL=001, ALU_RES=32'h5 -> next cycle REG_WE=1, REG_WADDR=2, REG_WDAT=5; STALL never 1.
REQ-030 Load with writeback OPCODE=32'hE5B12004, beat0 WB_CTL=111 MEM_DAT=32'hAA, beat1 WB_CTL=001 ALU_RES=32'h104 -> STALL=1 one cycle; writes R2=AA then R1=104 on consecutive cycles; GCnt 0,1,0.
REQ-031 Same load with COND_PASS=0 -> no STALL, REG_WE=0, GCnt stays 0.
REQ-032 Write to R15 (OPCODE[15:12]=F, WB_CTL=001) -> PC_WR=1 for exactly one cycle with REG_WE=1, REG_WADDR=F.
REQ-033 RST_N low mid-B1 of load -> all outputs 0 asynchronously; no base write after release; next MB starts at GCnt=0.
REQ-034 Back-to-back loads -> writes Rd1, Rn1, Rd2, Rn2 with STALL pattern 1,0,1,0.

Source files
------------

// File: rtl/wb_sequencer.sv
// Write-back beat sequencer: splits base-writeback loads into two register writes.
// Latency: one cycle from write-back inputs to registered write/forward/PC_WR outputs.
// Backpressure: STALL (combinational) holds upstream for exactly one cycle per multi-beat op.
//
// Ports
//   CLK, RST_N        : single rising-edge clock, asynchronous active-low reset
//   WB_VALID, OPCODE  : instruction present in write-back and its 32-bit word
//   COND_PASS         : condition field evaluated true
//   WB_CTL            : [2] forward data select, [1] write data select, [0] register write
//   ALU_RES, MEM_DAT  : candidate write / forward data
//   GCnt              : current beat index, fed back to write-back control decode
//   STALL             : hold upstream stages while the first beat of a multi-beat op retires
//   REG_WE/WADDR/WDAT : registered register-file write port
//   FWD_VALID/ADDR/DAT: registered forwarding bus
//   PC_WR             : registered one-cycle pulse when R15 is written (pipeline flush)
module wb_sequencer (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        WB_VALID,
    input  logic [31:0] OPCODE,
    input  logic        COND_PASS,
    input  logic [2:0]  WB_CTL,
    input  logic [31:0] ALU_RES,
    input  logic [31:0] MEM_DAT,
    output logic        GCnt,
    output logic        STALL,
    output logic        REG_WE,
    output logic [3:0]  REG_WADDR,
    output logic [31:0] REG_WDAT,
    output logic        FWD_VALID,
    output logic [3:0]  FWD_ADDR,
    output logic [31:0] FWD_DAT,
    output logic        PC_WR
);

    typedef enum logic {
        B0 = 1'b0,
        B1 = 1'b1
    } beat_e;

    beat_e state;

    logic        ls_class;
    logic        mb;
    logic        we_eff;
    logic [3:0]  sel_addr;
    logic [31:0] sel_wdat;
    logic [31:0] sel_fdat;

    // Opcode bits that the sequencer never looks at.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^{OPCODE[31:28], OPCODE[25:20], OPCODE[11:0]};

    // Load/store class: the only class that can carry a second (base) write.
    assign ls_class = (OPCODE[27:26] == 2'b01);

    // An instruction only becomes multi-beat if it will actually execute.
    assign mb = WB_VALID & COND_PASS & ls_class;

    assign we_eff = WB_VALID & COND_PASS & WB_CTL[0];

    // Beat 1 of a load/store writes the base register Rn; everything else writes Rd.
    assign sel_addr = (ls_class && (state == B1)) ? OPCODE[19:16] : OPCODE[15:12];

    assign sel_wdat = WB_CTL[1] ? MEM_DAT : ALU_RES;
    assign sel_fdat = WB_CTL[2] ? MEM_DAT : ALU_RES;

    assign GCnt = (state == B1);

    // Stall only while the first beat retires; gated by reset so it cannot leak
    // out while the sequencer is held in reset with live upstream inputs.
    assign STALL = RST_N & (state == B0) & mb;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= B0;
            REG_WE    <= 1'b0;
            REG_WADDR <= 4'h0;
            REG_WDAT  <= 32'h0;
            FWD_VALID <= 1'b0;
            FWD_ADDR  <= 4'h0;
            FWD_DAT   <= 32'h0;
            PC_WR     <= 1'b0;
        end else begin
            case (state)
                B0:      state <= mb ? B1 : B0;
                // Second beat always completes in one cycle, even if the
                // instruction was withdrawn.
                B1:      state <= B0;
                default: state <= B0;
            endcase

            REG_WE    <= we_eff;
            REG_WADDR <= sel_addr;
            REG_WDAT  <= sel_wdat;
            FWD_VALID <= we_eff;
            FWD_ADDR  <= sel_addr;
            FWD_DAT   <= sel_fdat;
            PC_WR     <= we_eff & (sel_addr == 4'hF);
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Testbench for wb_sequencer: directed vector table, reset/withdraw corner sequences,
// and random instruction streams checked against an instruction-level model.
// Inputs driven after the falling edge; outputs sampled 1 time unit after edges.
module tb_wb_sequencer;

    logic        CLK;
    logic        RST_N;
    logic        WB_VALID;
    logic [31:0] OPCODE;
    logic        COND_PASS;
    logic [2:0]  WB_CTL;
    logic [31:0] ALU_RES;
    logic [31:0] MEM_DAT;
    logic        GCnt;
    logic        STALL;
    logic        REG_WE;
    logic [3:0]  REG_WADDR;
    logic [31:0] REG_WDAT;
    logic        FWD_VALID;
    logic [3:0]  FWD_ADDR;
    logic [31:0] FWD_DAT;
    logic        PC_WR;

    int n_checks = 0;
    int n_fail   = 0;

    wb_sequencer dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .WB_VALID  (WB_VALID),
        .OPCODE    (OPCODE),
        .COND_PASS (COND_PASS),
        .WB_CTL    (WB_CTL),
        .ALU_RES   (ALU_RES),
        .MEM_DAT   (MEM_DAT),
        .GCnt      (GCnt),
        .STALL     (STALL),
        .REG_WE    (REG_WE),
        .REG_WADDR (REG_WADDR),
        .REG_WDAT  (REG_WDAT),
        .FWD_VALID (FWD_VALID),
        .FWD_ADDR  (FWD_ADDR),
        .FWD_DAT   (FWD_DAT),
        .PC_WR     (PC_WR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        v;
        logic        c;
        logic [31:0] op;
        logic [2:0]  ctl;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        e_stall;
        logic        e_g;
        logic        e_we;
        logic [3:0]  e_a;
        logic [31:0] e_wd;
        logic [31:0] e_fd;
        logic        e_pc;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gcnt"},  {31'h0, GCnt},      32'h0);
        chk({tag, "_stall"}, {31'h0, STALL},     32'h0);
        chk({tag, "_we"},    {31'h0, REG_WE},    32'h0);
        chk({tag, "_waddr"}, {28'h0, REG_WADDR}, 32'h0);
        chk({tag, "_wdat"},  REG_WDAT,           32'h0);
        chk({tag, "_fvld"},  {31'h0, FWD_VALID}, 32'h0);
        chk({tag, "_faddr"}, {28'h0, FWD_ADDR},  32'h0);
        chk({tag, "_fdat"},  FWD_DAT,            32'h0);
        chk({tag, "_pcwr"},  {31'h0, PC_WR},     32'h0);
    endtask

    // One write-back cycle: called just after a falling edge, returns just after the next one.
    task automatic cycle(input logic v, input logic c, input logic [31:0] op,
                         input logic [2:0] ctl, input logic [31:0] alu, input logic [31:0] mem,
                         input logic e_stall, input logic e_g, input logic e_we,
                         input logic [3:0] e_a, input logic [31:0] e_wd,
                         input logic [31:0] e_fd, input logic e_pc, input string tag);
        WB_VALID  = v;
        COND_PASS = c;
        OPCODE    = op;
        WB_CTL    = ctl;
        ALU_RES   = alu;
        MEM_DAT   = mem;
        #1;
        chk({tag, "_stall"}, {31'h0, STALL}, {31'h0, e_stall});
        chk({tag, "_gcnt"},  {31'h0, GCnt},  {31'h0, e_g});
        @(posedge CLK);
        #1;
        chk({tag, "_we"},    {31'h0, REG_WE},    {31'h0, e_we});
        chk({tag, "_waddr"}, {28'h0, REG_WADDR}, {28'h0, e_a});
        chk({tag, "_wdat"},  REG_WDAT,           e_wd);
        chk({tag, "_fvld"},  {31'h0, FWD_VALID}, {31'h0, e_we});
        chk({tag, "_faddr"}, {28'h0, FWD_ADDR},  {28'h0, e_a});
        chk({tag, "_fdat"},  FWD_DAT,            e_fd);
        chk({tag, "_pcwr"},  {31'h0, PC_WR},     {31'h0, e_pc});
        @(negedge CLK);
    endtask

    initial begin
        logic        v, v2, c, multi, we;
        logic [31:0] op, alu, mem;
        logic [2:0]  ctl;
        logic [3:0]  a;

        // Directed vectors, applied back-to-back from B0.
        //           v     c     opcode        ctl     alu           mem           stl   g     we    addr  wdat          fdat          pc
        vt[0]  = '{1'b1, 1'b1, 32'hE0812003, 3'b001, 32'h5,        32'h77,       1'b0, 1'b0, 1'b1, 4'h2, 32'h5,        32'h5,        1'b0};
        vt[1]  = '{1'b1, 1'b1, 32'hE5B12004, 3'b111, 32'h104,      32'hAA,       1'b1, 1'b0, 1'b1, 4'h2, 32'hAA,       32'hAA,       1'b0};
        vt[2]  = '{1'b1, 1'b1, 32'hE5B12004, 3'b001, 32'h104,      32'hAA,       1'b0, 1'b1, 1'b1, 4'h1, 32'h104,      32'h104,      1'b0};
        vt[3]  = '{1'b1, 1'b0, 32'hE5B12004, 3'b111, 32'h104,      32'hAA,       1'b0, 1'b0, 1'b0, 4'h2, 32'hAA,       32'hAA,       1'b0};
        vt[4]  = '{1'b1, 1'b0, 32'hE5B12004, 3'b001, 32'h104,      32'hAA,       1'b0, 1'b0, 1'b0, 4'h2, 32'h104,      32'h104,      1'b0};
        vt[5]  = '{1'b1, 1'b1, 32'hE081F003, 3'b001, 32'h1000,     32'h0,        1'b0, 1'b0, 1'b1, 4'hF, 32'h1000,     32'h1000,     1'b1};
        vt[6]  = '{1'b0, 1'b0, 32'h0,        3'b000, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0};
        vt[7]  = '{1'b1, 1'b1, 32'hE5B12004, 3'b111, 32'h104,      32'hBB,       1'b1, 1'b0, 1'b1, 4'h2, 32'hBB,       32'hBB,       1'b0};
        vt[8]  = '{1'b1, 1'b1, 32'hE5B12004, 3'b001, 32'h104,      32'hBB,       1'b0, 1'b1, 1'b1, 4'h1, 32'h104,      32'h104,      1'b0};
        vt[9]  = '{1'b1, 1'b1, 32'hE5934008, 3'b111, 32'h200,      32'h11,       1'b1, 1'b0, 1'b1, 4'h4, 32'h11,       32'h11,       1'b0};
        vt[10] = '{1'b1, 1'b1, 32'hE5934008, 3'b001, 32'h204,      32'h11,       1'b0, 1'b1, 1'b1, 4'h3, 32'h204,      32'h204,      1'b0};
        vt[11] = '{1'b1, 1'b1, 32'hE0812003, 3'b101, 32'h55,       32'h66,       1'b0, 1'b0, 1'b1, 4'h2, 32'h55,       32'h66,       1'b0};
        vt[12] = '{1'b1, 1'b1, 32'hE0812003, 3'b010, 32'h99,       32'h88,       1'b0, 1'b0, 1'b0, 4'h2, 32'h88,       32'h99,       1'b0};
        vt[13] = '{1'b1, 1'b1, 32'hE5BF1004, 3'b011, 32'h44,       32'h33,       1'b1, 1'b0, 1'b1, 4'h1, 32'h33,       32'h44,       1'b0};
        vt[14] = '{1'b1, 1'b1, 32'hE5BF1004, 3'b001, 32'h48,       32'h33,       1'b0, 1'b1, 1'b1, 4'hF, 32'h48,       32'h48,       1'b1};

        // Reset with a live multi-beat instruction presented: STALL must stay low.
        RST_N     = 1'b1;
        WB_VALID  = 1'b1;
        COND_PASS = 1'b1;
        OPCODE    = 32'hE5B12004;
        WB_CTL    = 3'b111;
        ALU_RES   = 32'h104;
        MEM_DAT   = 32'hAA;
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check_all_zero("reset_held");
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cycle(vt[i].v, vt[i].c, vt[i].op, vt[i].ctl, vt[i].alu, vt[i].mem,
                  vt[i].e_stall, vt[i].e_g, vt[i].e_we, vt[i].e_a, vt[i].e_wd,
                  vt[i].e_fd, vt[i].e_pc, $sformatf("vec%0d", i));
        end

        // Reset arriving during beat 1 of a load: base write abandoned.
        cycle(1'b1, 1'b1, 32'hE5B12004, 3'b111, 32'h104, 32'hCC,
              1'b1, 1'b0, 1'b1, 4'h2, 32'hCC, 32'hCC, 1'b0, "rstb1_beat0");
        WB_CTL = 3'b001;
        #1;
        chk("rstb1_pre_gcnt", {31'h0, GCnt}, 32'h1);
        RST_N = 1'b0;
        #1;
        check_all_zero("rstb1_async");
        @(posedge CLK);
        #1;
        check_all_zero("rstb1_held");
        @(negedge CLK);
        RST_N = 1'b1;
        cycle(1'b1, 1'b1, 32'hE5B12004, 3'b001, 32'h104, 32'hCC,
              1'b1, 1'b0, 1'b1, 4'h2, 32'h104, 32'h104, 1'b0, "rstb1_restart0");
        cycle(1'b1, 1'b1, 32'hE5B12004, 3'b001, 32'h108, 32'hCC,
              1'b0, 1'b1, 1'b1, 4'h1, 32'h108, 32'h108, 1'b0, "rstb1_restart1");

        // Instruction withdrawn during beat 1: no write, back to beat 0.
        cycle(1'b1, 1'b1, 32'hE5B12004, 3'b111, 32'h104, 32'hDD,
              1'b1, 1'b0, 1'b1, 4'h2, 32'hDD, 32'hDD, 1'b0, "wdraw_beat0");
        cycle(1'b0, 1'b1, 32'hE5B12004, 3'b001, 32'h104, 32'hDD,
              1'b0, 1'b1, 1'b0, 4'h1, 32'h104, 32'h104, 1'b0, "wdraw_beat1");
        cycle(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0,
              1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, "wdraw_after");

        // Random instruction stream: the model knows, per instruction, how many
        // beats it takes and which register each beat writes.
        for (int i = 0; i < 400; i++) begin
            op = $urandom;
            if ($urandom_range(0, 1) == 1) op[27:26] = 2'b01;
            if ($urandom_range(0, 7) == 0) op[15:12] = 4'hF;
            if ($urandom_range(0, 7) == 0) op[19:16] = 4'hF;
            v     = ($urandom_range(0, 7) != 0);
            c     = ($urandom_range(0, 5) != 0);
            ctl   = 3'($urandom);
            alu   = $urandom;
            mem   = $urandom;
            multi = v && c && (op[27:26] == 2'b01);
            we    = v && c && ctl[0];
            a     = op[15:12];
            cycle(v, c, op, ctl, alu, mem, multi, 1'b0, we, a,
                  ctl[1] ? mem : alu, ctl[2] ? mem : alu, we && (a == 4'hF),
                  $sformatf("rnd%0d_b0", i));
            if (multi) begin
                v2  = ($urandom_range(0, 7) != 0);
                ctl = 3'($urandom);
                alu = $urandom;
                mem = $urandom;
                we  = v2 && c && ctl[0];
                a   = op[19:16];
                cycle(v2, c, op, ctl, alu, mem, 1'b0, 1'b1, we, a,
                      ctl[1] ? mem : alu, ctl[2] ? mem : alu, we && (a == 4'hF),
                      $sformatf("rnd%0d_b1", i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
